// File: rtl/note_pkg.sv
// Shared row type, default screen geometry and the x-to-lane helper
// for the falling-note engine.
package note_pkg;

    localparam int DEF_LANES    = 4;
    localparam int DEF_LANE_W   = 160;
    localparam int DEF_NOTE_H   = 32;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_DIV_W    = 20;
    localparam int DEF_HIT_Y    = 440;

    typedef struct packed {
        logic [9:0]           y;
        logic [DEF_LANES-1:0] mask;
        logic                 valid;
    } row_t;

    // Returns 'lanes' (an out-of-range index) when x is right of the last lane.
    function automatic int lane_of(input logic [9:0] x, input int lane_w, input int lanes);
        int lane;
        lane = int'(x) / lane_w;
        return (lane < lanes) ? lane : lanes;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Programmable scroll tick: one-clock step every speed_div+1 clocks.
module step_timer #(
    parameter int DIV_W = 20
) (
    input  logic             CLOCK_25,
    input  logic             reset,
    input  logic [DIV_W-1:0] speed_div,
    output logic             step
);

    logic [DIV_W-1:0] count;

    // Equality compare lets a lowered divider wrap the counter through 2^DIV_W.
    assign step = !reset && (count == speed_div);

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            count <= '0;
        end else if (step) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/note_row_scroller.sv
// Falling-note ring buffer: spawns, scrolls, retires and draws note rows.
// Define HIT_CLEAR_EN to add the hit_clear input that removes struck lanes.
module note_row_scroller
    import note_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int LANE_W   = DEF_LANE_W,
    parameter int NOTE_H   = DEF_NOTE_H,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int HIT_Y    = DEF_HIT_Y
) (
    input  logic                       CLOCK_25,
    input  logic                       reset,
    input  logic [DIV_W-1:0]           speed_div,
    input  logic                       spawn_valid,
    input  logic [LANES-1:0]           spawn_mask,
    output logic                       spawn_ready,
    input  logic [9:0]                 next_x,
    input  logic [9:0]                 next_y,
`ifdef HIT_CLEAR_EN
    input  logic [LANES-1:0]           hit_clear,
`endif
    output logic [LANES-1:0]           sprite_pattern,
    output logic [LANES-1:0]           hit_window,
    output logic                       row_retired,
    output logic [LANES-1:0]           retired_mask,
    output logic [$clog2(DEPTH+1)-1:0] row_count
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int HALF = NOTE_H / 2;

    logic [9:0]       y_q    [DEPTH];
    logic [LANES-1:0] mask_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    newest;

    logic             step;
    logic             accept;
    logic             step_retire;
    logic             retire;
    logic [LANES-1:0] draw;
    logic [LANES-1:0] hit_next;
    int               draw_lane;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    step_timer #(.DIV_W(DIV_W)) u_step_timer (
        .CLOCK_25  (CLOCK_25),
        .reset     (reset),
        .speed_div (speed_div),
        .step      (step)
    );

    // A new row may only enter once the previous one has fully cleared the top edge.
    assign newest      = (tail == '0) ? PW'(DEPTH - 1) : tail - PW'(1);
    assign spawn_ready = !reset && (row_count < CW'(DEPTH)) &&
                         ((row_count == '0) || (y_q[newest] >= 10'(NOTE_H)));
    assign accept      = spawn_valid && spawn_ready;
    assign step_retire = step && valid_q[head] && (y_q[head] == 10'(SCREEN_H));

`ifdef HIT_CLEAR_EN
    logic             kill_pending;
    logic [LANES-1:0] clear_bits;

    assign clear_bits = hit_clear & hit_window;
    assign retire     = step_retire || kill_pending;
`else
    assign retire     = step_retire;
`endif

    assign draw_lane = lane_of(next_x, LANE_W, LANES);

    // Window compare done in 11 bits so rows near the top never underflow.
    always_comb begin
        draw = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (valid_q[r] &&
                (({1'b0, next_y} + 11'(HALF)) >= {1'b0, y_q[r]}) &&
                ({1'b0, next_y} < ({1'b0, y_q[r]} + 11'(HALF)))) begin
                for (int l = 0; l < LANES; l++) begin
                    if ((draw_lane == l) && mask_q[r][l]) begin
                        draw[l] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        hit_next = '0;
        if (valid_q[head] &&
            (({1'b0, y_q[head]} + 11'(HALF)) >= 11'(HIT_Y)) &&
            ({1'b0, y_q[head]} <= 11'(HIT_Y + HALF))) begin
            hit_next = mask_q[head];
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            row_count      <= '0;
            valid_q        <= '0;
            sprite_pattern <= '0;
            hit_window     <= '0;
            row_retired    <= 1'b0;
            retired_mask   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                y_q[i]    <= '0;
                mask_q[i] <= '0;
            end
`ifdef HIT_CLEAR_EN
            kill_pending   <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (step && valid_q[i] && !(retire && (PW'(i) == head))) begin
                    y_q[i] <= y_q[i] + 10'd1;
                end
            end
`ifdef HIT_CLEAR_EN
            // An emptied oldest row is retired one clock later with a zero mask.
            if (!retire && valid_q[head]) begin
                mask_q[head] <= mask_q[head] & ~clear_bits;
            end
            kill_pending <= !retire && valid_q[head] && (mask_q[head] != '0) &&
                            ((mask_q[head] & ~clear_bits) == '0);
`endif
            if (retire) begin
                valid_q[head] <= 1'b0;
                head          <= ptr_inc(head);
            end
            if (accept) begin
                y_q[tail]     <= '0;
                mask_q[tail]  <= spawn_mask;
                valid_q[tail] <= 1'b1;
                tail          <= ptr_inc(tail);
            end
            if (accept && !retire) begin
                row_count <= row_count + CW'(1);
            end else if (!accept && retire) begin
                row_count <= row_count - CW'(1);
            end
            row_retired    <= retire;
            retired_mask   <= retire ? mask_q[head] : '0;
            sprite_pattern <= draw;
            hit_window     <= hit_next;
        end
    end

endmodule

// File: tb/tb_note_row_scroller.sv
// Self-checking bench for note_row_scroller against a queue-based row model.
// Build with HIT_CLEAR_EN defined to also exercise the hit_clear lane removal.
module tb_note_row_scroller;

    logic        clk;
    logic        reset;
    logic [19:0] speed_div;
    logic        spawn_valid;
    logic [3:0]  spawn_mask;
    logic        spawn_ready;
    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic [3:0]  sprite_pattern;
    logic [3:0]  hit_window;
    logic        row_retired;
    logic [3:0]  retired_mask;
    logic [2:0]  row_count;
`ifdef HIT_CLEAR_EN
    logic [3:0]  hit_clear;
`endif

    int checks   = 0;
    int failures = 0;

    note_pkg::row_t q[$];
    logic [19:0]    m_cnt;
    logic           m_kill;
    logic [3:0]     e_sprite;
    logic [3:0]     e_hit;
    logic           e_retired;
    logic [3:0]     e_rmask;

    note_row_scroller dut (
        .CLOCK_25       (clk),
        .reset          (reset),
        .speed_div      (speed_div),
        .spawn_valid    (spawn_valid),
        .spawn_mask     (spawn_mask),
        .spawn_ready    (spawn_ready),
        .next_x         (next_x),
        .next_y         (next_y),
`ifdef HIT_CLEAR_EN
        .hit_clear      (hit_clear),
`endif
        .sprite_pattern (sprite_pattern),
        .hit_window     (hit_window),
        .row_retired    (row_retired),
        .retired_mask   (retired_mask),
        .row_count      (row_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelReady();
        return !reset && (q.size() < 4) && ((q.size() == 0) || (q[q.size()-1].y >= 10'd32));
    endfunction

    // Behavioural model: rows are a FIFO queue, outputs follow the spec's arithmetic.
    task automatic modelStep();
        logic [3:0] nsprite;
        logic [3:0] nhit;
        logic [3:0] clr;
        logic       acc;
        logic       stp;
        logic       ret;
        logic       kill_new;
        int         lane;
        int         dy;
        if (reset) begin
            q.delete();
            m_cnt = '0; m_kill = 1'b0;
            e_sprite = '0; e_hit = '0; e_retired = 1'b0; e_rmask = '0;
            return;
        end
        nsprite = '0;
        if (int'(next_x) < 640) begin
            lane = int'(next_x) / 160;
            foreach (q[i])
                if (int'(next_y) >= int'(q[i].y) - 16 && int'(next_y) < int'(q[i].y) + 16 && q[i].mask[lane])
                    nsprite[lane] = 1'b1;
        end
        nhit = '0;
        if (q.size() > 0) begin
            dy = int'(q[0].y) - 440;
            if (dy < 0) dy = -dy;
            if (dy <= 16) nhit = q[0].mask;
        end
        acc = spawn_valid && modelReady();
        stp = (m_cnt == speed_div);
        m_cnt = stp ? 20'd0 : m_cnt + 20'd1;
        clr = '0;
`ifdef HIT_CLEAR_EN
        clr = hit_clear & e_hit;
`endif
        ret = m_kill || (stp && q.size() > 0 && q[0].y == 10'd480);
        e_retired = ret;
        e_rmask = ret ? q[0].mask : 4'd0;
        kill_new = !ret && q.size() > 0 && q[0].mask != 0 && (q[0].mask & ~clr) == 0;
        if (ret) void'(q.pop_front());
        else if (q.size() > 0) q[0].mask = q[0].mask & ~clr;
        if (stp) foreach (q[i]) q[i].y = q[i].y + 10'd1;
        if (acc) q.push_back('{y: 10'd0, mask: spawn_mask, valid: 1'b1});
        m_kill = kill_new;
        e_sprite = nsprite;
        e_hit = nhit;
    endtask

    task automatic checkOutput();
        checkVal("row_count", 32'(row_count), 32'(q.size()));
        checkVal("spawn_ready", 32'(spawn_ready), 32'(modelReady()));
        checkVal("sprite_pattern", 32'(sprite_pattern), 32'(e_sprite));
        checkVal("hit_window", 32'(hit_window), 32'(e_hit));
        checkVal("row_retired", 32'(row_retired), 32'(e_retired));
        checkVal("retired_mask", 32'(retired_mask), 32'(e_rmask));
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] mask, input logic [9:0] nx, input logic [9:0] ny);
        spawn_valid = valid;
        spawn_mask  = mask;
        next_x      = nx;
        next_y      = ny;
    endtask

    task automatic doReset();
        reset = 1'b1;
        spawn_valid = 1'b0;
        cycle();
        cycle();
        @(negedge clk);
        checkVal("reset_ready", 32'(spawn_ready), 32'd0);
        checkVal("reset_count", 32'(row_count), 32'd0);
        checkVal("reset_sprite", 32'(sprite_pattern), 32'd0);
        cycle();
        reset = 1'b0;
    endtask

    task automatic spawnOne(input logic [3:0] mask);
        spawn_valid = 1'b1;
        spawn_mask  = mask;
        cycle();
        spawn_valid = 1'b0;
    endtask

    task automatic waitFrontY(input int target, input int budget, input string name);
        int  n = 0;
        bit  found = 0;
        while (n < budget) begin
            if (q.size() > 0 && int'(q[0].y) == target) begin
                found = 1;
                break;
            end
            cycle();
            n++;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL %s: timeout after %0d cycles, required front y=%0d", name, budget, target);
        end
    endtask

    initial begin
        reset = 1'b1;
        speed_div = '0;
        applyStimulus(1'b0, 4'b0000, 10'd0, 10'd0);
`ifdef HIT_CLEAR_EN
        hit_clear = '0;
`endif

        // 1: single row scrolling every clock, drawn at the top in lane 0
        doReset();
        applyStimulus(1'b1, 4'b0001, 10'd10, 10'd0);
        cycle();
        spawn_valid = 1'b0;
        @(negedge clk);
        checkVal("t1_count", 32'(row_count), 32'd1);
        cycle();
        @(negedge clk);
        checkVal("t1_sprite", 32'(sprite_pattern), 32'b0001);
        checkVal("t1_model_y1", 32'(q[0].y), 32'd1);
        cycle();
        checkVal("t1_model_y2", 32'(q[0].y), 32'd2);

        // 2: speed_div=3 -> one step per four clocks
        doReset();
        speed_div = 20'd3;
        applyStimulus(1'b1, 4'b0001, 10'd10, 10'd20);
        cycle();
        spawn_valid = 1'b0;
        repeat (19) cycle();
        @(negedge clk);
        checkVal("t2_sprite_y4", 32'(sprite_pattern), 32'b0000);
        cycle();
        @(negedge clk);
        checkVal("t2_sprite_y5", 32'(sprite_pattern), 32'b0001);
        checkVal("t2_model_y", 32'(q[0].y), 32'd5);

        // 3: continuous spawn fills four rows spaced by the note height
        doReset();
        speed_div = 20'd0;
        applyStimulus(1'b1, 4'b0100, 10'd700, 10'd0);
        repeat (33) cycle();
        @(negedge clk);
        checkVal("t3_count_1", 32'(row_count), 32'd1);
        checkVal("t3_ready_y32", 32'(spawn_ready), 32'd1);
        cycle();
        @(negedge clk);
        checkVal("t3_count_2", 32'(row_count), 32'd2);
        checkVal("t3_ready_y0", 32'(spawn_ready), 32'd0);
        repeat (70) cycle();
        @(negedge clk);
        checkVal("t3_count_full", 32'(row_count), 32'd4);
        checkVal("t3_ready_full", 32'(spawn_ready), 32'd0);
        spawn_valid = 1'b0;

        // 4: retire at the bottom coinciding with an accepted spawn
        doReset();
        applyStimulus(1'b0, 4'b0000, 10'd100, 10'd300);
        spawnOne(4'b0100);
        repeat (40) cycle();
        spawnOne(4'b0010);
        repeat (40) cycle();
        spawnOne(4'b0001);
        waitFrontY(480, 600, "t4_wait_bottom");
        spawn_valid = 1'b1;
        spawn_mask  = 4'b1000;
        @(negedge clk);
        checkVal("t4_count_before", 32'(row_count), 32'd3);
        checkVal("t4_ready", 32'(spawn_ready), 32'd1);
        cycle();
        spawn_valid = 1'b0;
        @(negedge clk);
        checkVal("t4_retired", 32'(row_retired), 32'd1);
        checkVal("t4_retired_mask", 32'(retired_mask), 32'b0100);
        checkVal("t4_count_after", 32'(row_count), 32'd3);
        cycle();
        @(negedge clk);
        checkVal("t4_retired_pulse", 32'(row_retired), 32'd0);

        // Reset while rows are scrolling flushes without a retire pulse
        repeat (5) cycle();
        reset = 1'b1;
        @(negedge clk);
        checkVal("rst_mid_ready", 32'(spawn_ready), 32'd0);
        cycle();
        @(negedge clk);
        checkVal("rst_mid_count", 32'(row_count), 32'd0);
        checkVal("rst_mid_retired", 32'(row_retired), 32'd0);
        cycle();
        reset = 1'b0;

        // 5: drawing window and lane boundaries around a row frozen at y=8
        doReset();
        speed_div = 20'd0;
        applyStimulus(1'b0, 4'b0000, 10'd200, 10'd0);
        spawnOne(4'b0010);
        waitFrontY(8, 20, "t5_wait_y8");
        speed_div = 20'd1000;
        cycle();
        @(negedge clk);
        checkVal("t5_top_edge", 32'(sprite_pattern), 32'b0010);
        next_y = 10'd23;
        cycle();
        @(negedge clk);
        checkVal("t5_bottom_in", 32'(sprite_pattern), 32'b0010);
        next_y = 10'd24;
        cycle();
        @(negedge clk);
        checkVal("t5_bottom_out", 32'(sprite_pattern), 32'b0000);
        next_x = 10'd640;
        next_y = 10'd8;
        cycle();
        @(negedge clk);
        checkVal("t5_x_off", 32'(sprite_pattern), 32'b0000);
        next_x = 10'd319;
        cycle();
        @(negedge clk);
        checkVal("t5_lane_edge", 32'(sprite_pattern), 32'b0010);
        next_x = 10'd320;
        cycle();
        @(negedge clk);
        checkVal("t5_next_lane", 32'(sprite_pattern), 32'b0000);

        // spawn_mask of zero takes a slot but is never drawn
        doReset();
        speed_div = 20'd0;
        applyStimulus(1'b0, 4'b0000, 10'd10, 10'd0);
        spawnOne(4'b0000);
        cycle();
        @(negedge clk);
        checkVal("zero_mask_count", 32'(row_count), 32'd1);
        checkVal("zero_mask_sprite", 32'(sprite_pattern), 32'b0000);

`ifdef HIT_CLEAR_EN
        // 6: hit_clear removes struck lanes; an emptied row retires with mask 0
        doReset();
        speed_div = 20'd0;
        applyStimulus(1'b0, 4'b0000, 10'd700, 10'd0);
        spawnOne(4'b0011);
        waitFrontY(440, 500, "t6_wait_hit");
        speed_div = 20'd1000;
        cycle();
        cycle();
        @(negedge clk);
        checkVal("t6_hit_full", 32'(hit_window), 32'b0011);
        hit_clear = 4'b0001;
        cycle();
        hit_clear = 4'b0000;
        cycle();
        @(negedge clk);
        checkVal("t6_hit_partial", 32'(hit_window), 32'b0010);
        hit_clear = 4'b0010;
        cycle();
        hit_clear = 4'b0000;
        @(negedge clk);
        checkVal("t6_no_retire_yet", 32'(row_retired), 32'd0);
        cycle();
        @(negedge clk);
        checkVal("t6_retired", 32'(row_retired), 32'd1);
        checkVal("t6_retired_mask", 32'(retired_mask), 32'b0000);
        checkVal("t6_count", 32'(row_count), 32'd0);
`endif

        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
